// File: rtl/coin_accumulator.sv
// Coin-slot front end: two-flop synchronisers and debouncers on both slots feed a
// credit FSM that accumulates a 3-bit saturating credit with vend clear and refund.
module coin_accumulator #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PRICE           = 2,
  parameter int unsigned MAX_CREDIT      = 7,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic       clk,
  input  logic       start,
  input  logic       coin_a,
  input  logic       coin_b,
  input  logic       cancel,
  input  logic       vend_done,
  output logic [2:0] coins,
  output logic       credit_ok,
  output logic       coin_reject,
  output logic [2:0] refund,
  output logic       refund_valid
);

  localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] PRICE_W  = 4'(PRICE);
  localparam logic [3:0] MAX_W    = 4'(MAX_CREDIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REFUND  = 2'd2
  } state_e;

  logic [1:0] raw;
  logic [1:0] qual;

  assign raw = {coin_b, coin_a};

  // Slot 0 is coin_a (value 1), slot 1 is coin_b (value 2).
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic       meta_q;
    logic       sync_q;
    logic       qual_q;
    logic       qual_d;
    logic [3:0] deb_q;
    logic [3:0] deb_d;

    // Counter saturates at DEBOUNCE_CYCLES so a held coin qualifies only once.
    always_comb begin
      deb_d  = 4'd0;
      qual_d = 1'b0;
      if (sync_q) begin
        deb_d  = (deb_q == DEB_MAX) ? DEB_MAX : deb_q + 4'd1;
        qual_d = (deb_q == DEB_LAST);
      end
    end

    always_ff @(posedge clk or negedge start) begin
      if (!start) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
        deb_q  <= 4'd0;
        qual_q <= 1'b0;
      end else begin
        meta_q <= raw[gi];
        sync_q <= meta_q;
        deb_q  <= deb_d;
        qual_q <= qual_d;
      end
    end

    assign qual[gi] = qual_q;
  end

  state_e     state_q, state_d;
  logic [2:0] coins_q, coins_d;
  logic [7:0] timer_q, timer_d;
  logic       credit_ok_q, credit_ok_d;
  logic       reject_q, reject_d;
  logic [2:0] refund_q, refund_d;
  logic       refund_valid_q, refund_valid_d;

  logic       any_coin;
  logic [2:0] coin_val;
  logic [3:0] sum_a, sum_b, sum_ab;
  logic [2:0] acc_credit;
  logic       acc_any;
  logic       acc_rej;

  assign any_coin = qual[0] | qual[1];
  assign coin_val = {1'b0, qual[1], qual[0]};
  assign sum_a    = {1'b0, coins_q} + 4'd1;
  assign sum_b    = {1'b0, coins_q} + 4'd2;
  assign sum_ab   = {1'b0, coins_q} + 4'd3;

  // Coin acceptance against the current credit; coin_b is tried before coin_a
  // when both cannot fit together.
  always_comb begin
    acc_credit = coins_q;
    acc_any    = 1'b0;
    acc_rej    = 1'b0;
    if (qual[0] && qual[1]) begin
      if (sum_ab <= MAX_W) begin
        acc_credit = sum_ab[2:0];
        acc_any    = 1'b1;
      end else if (sum_b <= MAX_W) begin
        acc_credit = sum_b[2:0];
        acc_any    = 1'b1;
        acc_rej    = 1'b1;
      end else if (sum_a <= MAX_W) begin
        acc_credit = sum_a[2:0];
        acc_any    = 1'b1;
        acc_rej    = 1'b1;
      end else begin
        acc_rej    = 1'b1;
      end
    end else if (qual[1]) begin
      if (sum_b <= MAX_W) begin
        acc_credit = sum_b[2:0];
        acc_any    = 1'b1;
      end else begin
        acc_rej    = 1'b1;
      end
    end else if (qual[0]) begin
      if (sum_a <= MAX_W) begin
        acc_credit = sum_a[2:0];
        acc_any    = 1'b1;
      end else begin
        acc_rej    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    coins_d        = coins_q;
    timer_d        = timer_q;
    reject_d       = 1'b0;
    refund_d       = 3'd0;
    refund_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        coins_d = 3'd0;
        timer_d = 8'd0;
        if (any_coin) begin
          state_d = S_COLLECT;
          coins_d = coin_val;
        end
      end

      S_COLLECT: begin
        if (vend_done && ({1'b0, coins_q} >= PRICE_W)) begin
          // A coin landing on the vend cycle starts a fresh credit.
          timer_d = 8'd0;
          if (any_coin) begin
            coins_d = coin_val;
          end else begin
            coins_d = 3'd0;
            state_d = S_IDLE;
          end
        end else begin
          coins_d  = acc_credit;
          reject_d = acc_rej;
          timer_d  = acc_any ? 8'd0 : timer_q + 8'd1;
          if (cancel || (timer_q == TMO_LAST)) begin
            state_d        = S_REFUND;
            refund_d       = acc_credit;
            refund_valid_d = 1'b1;
          end
        end
      end

      S_REFUND: begin
        coins_d  = 3'd0;
        timer_d  = 8'd0;
        reject_d = any_coin;
        state_d  = S_IDLE;
      end

      default: begin
        coins_d = 3'd0;
        timer_d = 8'd0;
        state_d = S_IDLE;
      end
    endcase

    credit_ok_d = ({1'b0, coins_d} >= PRICE_W);
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q        <= S_IDLE;
      coins_q        <= 3'd0;
      timer_q        <= 8'd0;
      credit_ok_q    <= 1'b0;
      reject_q       <= 1'b0;
      refund_q       <= 3'd0;
      refund_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      coins_q        <= coins_d;
      timer_q        <= timer_d;
      credit_ok_q    <= credit_ok_d;
      reject_q       <= reject_d;
      refund_q       <= refund_d;
      refund_valid_q <= refund_valid_d;
    end
  end

  assign coins        = coins_q;
  assign credit_ok    = credit_ok_q;
  assign coin_reject  = reject_q;
  assign refund       = refund_q;
  assign refund_valid = refund_valid_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Bench for coin_accumulator: directed scenarios plus random slot/cancel/vend
// traffic, every edge compared against a transaction-level credit model.
module tb_coin_accumulator;

  localparam int D     = 4;
  localparam int PRICE = 2;
  localparam int MAXC  = 7;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       start = 1'b1;
  logic       coin_a = 1'b0;
  logic       coin_b = 1'b0;
  logic       cancel = 1'b0;
  logic       vend_done = 1'b0;
  logic [2:0] coins;
  logic       credit_ok;
  logic       coin_reject;
  logic [2:0] refund;
  logic       refund_valid;

  always #5 clk = ~clk;

  coin_accumulator #(
    .DEBOUNCE_CYCLES(D),
    .PRICE(PRICE),
    .MAX_CREDIT(MAXC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .start(start),
    .coin_a(coin_a),
    .coin_b(coin_b),
    .cancel(cancel),
    .vend_done(vend_done),
    .coins(coins),
    .credit_ok(credit_ok),
    .coin_reject(coin_reject),
    .refund(refund),
    .refund_valid(refund_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // Model: a coin qualifies after D consecutive high samples and reaches the
  // credit logic 3 edges later (sync + debounce pipeline).
  int m_mode;   // 0 idle, 1 collecting, 2 refunding
  int m_credit, m_timer, m_rej, m_rv, m_ref;
  int run_a, run_b;
  bit pa [0:2];
  bit pb [0:2];

  task automatic model_reset();
    m_mode = 0; m_credit = 0; m_timer = 0; m_rej = 0; m_rv = 0; m_ref = 0;
    run_a = 0; run_b = 0;
    for (int i = 0; i < 3; i++) begin pa[i] = 1'b0; pb[i] = 1'b0; end
  endtask

  task automatic model_edge();
    int  qa, qb, nc;
    bit  acc, do_exit;
    qa = pa[2]; qb = pb[2];
    pa[2] = pa[1]; pa[1] = pa[0];
    pb[2] = pb[1]; pb[1] = pb[0];
    run_a = coin_a ? run_a + 1 : 0;
    run_b = coin_b ? run_b + 1 : 0;
    pa[0] = (run_a == D);
    pb[0] = (run_b == D);
    m_rej = 0;
    m_rv  = 0;
    if (m_mode == 0) begin
      if (qa || qb) begin m_mode = 1; m_credit = qa + 2 * qb; m_timer = 0; end
    end else if (m_mode == 2) begin
      m_rej = (qa || qb) ? 1 : 0;
      m_credit = 0;
      m_mode = 0;
    end else if (vend_done && m_credit >= PRICE) begin
      if (qa || qb) begin m_credit = qa + 2 * qb; m_timer = 0; end
      else begin m_credit = 0; m_mode = 0; end
    end else begin
      nc = m_credit; acc = 0;
      if (qa && qb && nc + 3 <= MAXC) begin nc += 3; acc = 1; end
      else begin
        if (qb) begin if (nc + 2 <= MAXC) begin nc += 2; acc = 1; end else m_rej = 1; end
        if (qa) begin if (nc + 1 <= MAXC) begin nc += 1; acc = 1; end else m_rej = 1; end
      end
      do_exit  = cancel || (m_timer == TMO - 1);
      m_timer  = acc ? 0 : m_timer + 1;
      m_credit = nc;
      if (do_exit) begin m_mode = 2; m_rv = 1; m_ref = nc; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("coins", coins, m_credit);
    check_eq("credit_ok", credit_ok, (m_credit >= PRICE) ? 1 : 0);
    check_eq("coin_reject", coin_reject, m_rej);
    check_eq("refund_valid", refund_valid, m_rv);
    if (m_rv != 0) check_eq("refund", refund, m_ref);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    start = 1'b0;
    #1;
    check_eq("rst_coins", coins, 0);
    check_eq("rst_credit_ok", credit_ok, 0);
    check_eq("rst_reject", coin_reject, 0);
    check_eq("rst_refund", refund, 0);
    check_eq("rst_refund_valid", refund_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // 1: coin_b held 6 cycles -> credit 2 six edges after first sample, once.
    coin_b = 1'b1;
    run(6);
    coin_b = 1'b0;
    check_eq("t1_before", coins, 0);
    step();
    check_eq("t1_latency", coins, 2);
    check_eq("t1_credit_ok", credit_ok, 1);
    run(5);
    check_eq("t1_once", coins, 2);
    cancel = 1'b1; step(); cancel = 1'b0;
    run(2);

    // 2: coin_a glitch shorter than the debounce window.
    coin_a = 1'b1; run(3); coin_a = 1'b0;
    run(8);
    check_eq("t2_glitch", coins, 0);

    // 3: build 6, coin_b overflows, then coin_a tops up to 7.
    for (int i = 0; i < 3; i++) begin
      coin_b = 1'b1; run(4); coin_b = 1'b0; run(1);
    end
    coin_b = 1'b1; step();
    coin_a = 1'b1; run(3);
    coin_b = 1'b0; step();
    coin_a = 1'b0; step();
    step();
    check_eq("t3_reject", coin_reject, 1);
    check_eq("t3_hold6", coins, 6);
    step();
    check_eq("t3_full", coins, 7);
    cancel = 1'b1; step(); cancel = 1'b0;
    check_eq("t3_refund7", refund, 7);
    run(2);

    // 4: credit 3 then cancel -> refund 3, then credit cleared.
    coin_b = 1'b1; run(4); coin_b = 1'b0; run(1);
    coin_a = 1'b1; run(4); coin_a = 1'b0; run(3);
    check_eq("t4_credit3", coins, 3);
    cancel = 1'b1; step(); cancel = 1'b0;
    check_eq("t4_rv", refund_valid, 1);
    check_eq("t4_refund", refund, 3);
    step();
    check_eq("t4_cleared", coins, 0);

    // 5: vend with credit 2 clears; vend with credit 1 is ignored.
    coin_b = 1'b1; run(4); coin_b = 1'b0; run(3);
    check_eq("t5_credit2", coins, 2);
    vend_done = 1'b1; step(); vend_done = 1'b0;
    check_eq("t5_vend_coins", coins, 0);
    check_eq("t5_vend_ok", credit_ok, 0);
    check_eq("t5_vend_norefund", refund_valid, 0);
    coin_a = 1'b1; run(4); coin_a = 1'b0; run(3);
    vend_done = 1'b1; step(); vend_done = 1'b0;
    check_eq("t5_low_vend", coins, 1);
    cancel = 1'b1; step(); cancel = 1'b0;
    run(2);

    // 6: idle timeout refunds credit 1 after TMO cycles; then async reset.
    coin_a = 1'b1; run(4); coin_a = 1'b0; run(3);
    check_eq("t6_credit1", coins, 1);
    run(TMO - 1);
    check_eq("t6_not_yet", refund_valid, 0);
    step();
    check_eq("t6_timeout_rv", refund_valid, 1);
    check_eq("t6_timeout_refund", refund, 1);
    step();
    coin_b = 1'b1; run(4); coin_b = 1'b0; run(4);
    check_eq("t6_collect", coins, 2);
    #2;
    do_reset();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) coin_a = ~coin_a;
      if ($urandom_range(0, 5) == 0) coin_b = ~coin_b;
      cancel    = ($urandom_range(0, 24) == 0);
      vend_done = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2;
        do_reset();
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
